// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin slot front end: sync, debounce, width measure, classify
//
// Purpose:
//   Conditions the raw coin-slot sensor and measures how long each coin
//   occludes it. The width decides the coin: rupee5, rupee10 or reject.
//   The result goes to the vending FSM as a single-cycle coin code, or to
//   the return gate as a single-cycle reject pulse.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   coin_sense  raw asynchronous slot sensor, high while a coin occludes it
//   accept_en   vending FSM can take credit, sampled only when classifying
//   coin        4'b0101 rupee5, 4'b1010 rupee10, otherwise 4'b0000
//   reject      one-cycle return-gate pulse
//   jam         high while the width counter is saturated and the sensor is high
//   busy        high whenever the acceptor is not idle

module coin_acceptor #(
  parameter int DEB_CYCLES     = 3,
  parameter int W5_MIN         = 8,
  parameter int W5_MAX         = 15,
  parameter int W10_MIN        = 20,
  parameter int W10_MAX        = 31,
  parameter int CNT_W          = 8,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  input  logic       accept_en,
  output logic [3:0] coin,
  output logic       reject,
  output logic       jam,
  output logic       busy
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [CNT_W-1:0] WIDTH_SAT = '1;
  localparam logic [CNT_W-1:0] W5_LO     = CNT_W'(W5_MIN);
  localparam logic [CNT_W-1:0] W5_HI     = CNT_W'(W5_MAX);
  localparam logic [CNT_W-1:0] W10_LO    = CNT_W'(W10_MIN);
  localparam logic [CNT_W-1:0] W10_HI    = CNT_W'(W10_MAX);
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  localparam logic [3:0] CODE_R5  = 4'b0101;
  localparam logic [3:0] CODE_R10 = 4'b1010;

  // Width windows must be ordered and strictly below the jam threshold,
  // otherwise a legal coin could saturate the counter.
  if (!(DEB_CYCLES >= 1 && HOLDOFF_CYCLES >= 0 &&
        W5_MIN <= W5_MAX && W5_MAX < W10_MIN && W10_MIN <= W10_MAX &&
        W10_MAX < (2 ** CNT_W) - 1)) begin : g_param_check
    $error("coin_acceptor: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEASURE,
    S_CLASSIFY,
    S_EMIT,
    S_HOLDOFF,
    S_JAM,
    S_DRAIN
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [DW-1:0] run_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [3:0]       coin_q, coin_d;
  logic             reject_q, reject_d;

  // Two-flop synchronizer followed by a run-length debouncer. The run count
  // only advances while the synchronized level disagrees with the debounced
  // level; any agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= coin_sense;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        run_q <= '0;
      end else if (run_q == DEB_LAST) begin
        db_q  <= sync2_q;
        run_q <= '0;
      end else begin
        run_q <= run_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      hcnt_q   <= '0;
      coin_q   <= 4'b0000;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      hcnt_q   <= hcnt_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  logic in_r5;
  logic in_r10;

  assign in_r5  = (width_q >= W5_LO)  && (width_q <= W5_HI);
  assign in_r10 = (width_q >= W10_LO) && (width_q <= W10_HI);

  // coin_d/reject_d default to zero, so the registered pulse lasts exactly
  // the one cycle spent in EMIT.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    hcnt_d   = hcnt_q;
    coin_d   = 4'b0000;
    reject_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (db_q) begin
          state_d = S_MEASURE;
          width_d = CNT_W'(1);
        end
      end

      S_MEASURE: begin
        if (!db_q) begin
          state_d = S_CLASSIFY;
        end else if (width_q == WIDTH_SAT - CNT_W'(1)) begin
          // Saturating step: the counter parks at all-ones inside JAM.
          width_d = WIDTH_SAT;
          state_d = S_JAM;
        end else begin
          width_d = width_q + CNT_W'(1);
        end
      end

      S_CLASSIFY: begin
        state_d = S_EMIT;
        if (accept_en && in_r5) begin
          coin_d = CODE_R5;
        end else if (accept_en && in_r10) begin
          coin_d = CODE_R10;
        end else begin
          reject_d = 1'b1;
        end
      end

      S_EMIT: begin
        hcnt_d = '0;
        if (HOLDOFF_CYCLES == 0) begin
          state_d = db_q ? S_DRAIN : S_IDLE;
        end else begin
          state_d = S_HOLDOFF;
        end
      end

      S_HOLDOFF: begin
        if (hcnt_q == HOLD_LAST) begin
          // A coin already present after holdoff is drained, never credited.
          state_d = db_q ? S_DRAIN : S_IDLE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      S_JAM, S_DRAIN: begin
        if (!db_q) begin
          state_d  = S_EMIT;
          reject_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = (state_q == S_JAM) && db_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor

module tb_coin_acceptor;

  localparam int DEB    = 3;
  localparam int W5MIN  = 8;
  localparam int W5MAX  = 15;
  localparam int W10MIN = 20;
  localparam int W10MAX = 31;
  localparam int CW     = 8;
  localparam int HOLD   = 4;
  localparam int JAMW   = (1 << CW) - 1;

  localparam int EV_NONE  = 0;
  localparam int EV_COIN5 = 1;
  localparam int EV_COIN10 = 2;
  localparam int EV_REJ   = 3;
  localparam int EV_JAM   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_sense = 1'b0;
  logic       accept_en = 1'b1;
  logic [3:0] coin;
  logic       reject;
  logic       jam;
  logic       busy;

  int errors = 0;
  int checks = 0;

  coin_acceptor #(
    .DEB_CYCLES(DEB), .W5_MIN(W5MIN), .W5_MAX(W5MAX), .W10_MIN(W10MIN),
    .W10_MAX(W10MAX), .CNT_W(CW), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .coin_sense(coin_sense), .accept_en(accept_en),
    .coin(coin), .reject(reject), .jam(jam), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference outcome of one clean insertion of n cycles.
  function automatic int expect_event(input int n, input bit acc);
    if (n < DEB) return EV_NONE;
    if (n >= JAMW) return EV_JAM;
    if (acc && n >= W5MIN && n <= W5MAX) return EV_COIN5;
    if (acc && n >= W10MIN && n <= W10MAX) return EV_COIN10;
    return EV_REJ;
  endfunction

  // Drives the sensor high for n cycles (accept_en forced low on cycles
  // [lo_from, lo_to)), then observes until the acceptor has settled.
  // Event times are cycles after the cycle that released the sensor.
  task automatic run_coin(input string tag, input int n, input bit acc,
                          input int lo_from, input int lo_to);
    int ev;
    int last;
    int coin_cnt, coin_val, coin_at, rej_cnt, rej_at, both, jam_cnt, busy_cnt, idle_at;
    ev = expect_event(n, acc);
    last = n + DEB + HOLD + 8;
    coin_cnt = 0; coin_val = 0; coin_at = -100; rej_cnt = 0; rej_at = -100;
    both = 0; jam_cnt = 0; busy_cnt = 0; idle_at = -100;
    accept_en = (lo_from <= 0 && lo_to > 0) ? 1'b0 : acc;
    coin_sense = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (coin != 4'b0000) begin
        coin_cnt++;
        coin_val = int'(coin);
        coin_at = c - n;
      end
      if (reject) begin
        rej_cnt++;
        rej_at = c - n;
      end
      if (reject && coin != 4'b0000) both++;
      if (jam) jam_cnt++;
      if (busy) busy_cnt++;
      else if (busy_cnt > 0 && idle_at == -100) idle_at = c - n;
      if (c == n) coin_sense = 1'b0;
      accept_en = (c >= lo_from && c < lo_to) ? 1'b0 : acc;
    end
    accept_en = 1'b1;
    chk($sformatf("%s overlap", tag), both, 0);
    chk($sformatf("%s final busy", tag), int'(busy), 0);
    case (ev)
      EV_NONE: begin
        chk($sformatf("%s coin count", tag), coin_cnt, 0);
        chk($sformatf("%s reject count", tag), rej_cnt, 0);
        chk($sformatf("%s busy cycles", tag), busy_cnt, 0);
      end
      EV_COIN5, EV_COIN10: begin
        chk($sformatf("%s coin count", tag), coin_cnt, 1);
        chk($sformatf("%s coin code", tag), coin_val, (ev == EV_COIN5) ? 5 : 10);
        chk($sformatf("%s coin time", tag), coin_at, DEB + 4);
        chk($sformatf("%s reject count", tag), rej_cnt, 0);
        chk($sformatf("%s idle time", tag), idle_at, DEB + 5 + HOLD);
      end
      EV_REJ: begin
        chk($sformatf("%s reject count", tag), rej_cnt, 1);
        chk($sformatf("%s reject time", tag), rej_at, DEB + 4);
        chk($sformatf("%s coin count", tag), coin_cnt, 0);
        chk($sformatf("%s idle time", tag), idle_at, DEB + 5 + HOLD);
      end
      default: begin
        chk($sformatf("%s jam cycles", tag), jam_cnt, n - JAMW);
        chk($sformatf("%s reject count", tag), rej_cnt, 1);
        chk($sformatf("%s reject time", tag), rej_at, DEB + 3);
        chk($sformatf("%s coin count", tag), coin_cnt, 0);
        chk($sformatf("%s idle time", tag), idle_at, DEB + 4 + HOLD);
      end
    endcase
    if (ev != EV_JAM) chk($sformatf("%s jam cycles", tag), jam_cnt, 0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int act;
    int n;
    bit acc;
    int lo_from;

    #1 rst = 1'b1;
    #1;
    chk("reset coin", int'(coin), 0);
    chk("reset reject", int'(reject), 0);
    chk("reset jam", int'(jam), 0);
    chk("reset busy", int'(busy), 0);
    idle(3);
    rst = 1'b0;
    idle(3);

    run_coin("r5 w10", 10, 1'b1, 0, 0);
    idle(5);
    run_coin("r10 w25 a", 25, 1'b1, 0, 0);
    idle(5);
    run_coin("r10 w25 b", 25, 1'b1, 0, 0);
    idle(5);
    run_coin("gap w17", 17, 1'b1, 0, 0);
    idle(5);
    run_coin("short w5", 5, 1'b1, 0, 0);
    idle(5);
    run_coin("glitch w2", 2, 1'b1, 0, 0);
    idle(5);
    run_coin("edge w8", 8, 1'b1, 0, 0);
    idle(5);
    run_coin("edge w31", 31, 1'b1, 0, 0);
    idle(5);
    run_coin("noaccept w10", 10, 1'b0, 0, 0);
    idle(5);
    run_coin("toggle w10", 10, 1'b1, 3, 7);
    idle(5);
    run_coin("jam w300", 300, 1'b1, 0, 0);
    idle(5);

    for (int i = 0; i < 14; i++) begin
      n = int'($urandom_range(1, 40));
      acc = ($urandom_range(0, 3) != 0);
      lo_from = int'($urandom_range(1, 40));
      run_coin($sformatf("rand%0d w%0d a%0d", i, n, acc), n, acc, lo_from,
               (lo_from < n) ? lo_from + int'($urandom_range(0, 3)) : 0);
      idle(int'($urandom_range(2, 8)));
    end

    // Reset while measuring: width reaches 12 at 5+12 cycles after the rise.
    coin_sense = 1'b1;
    idle(17);
    chk("pre-reset busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midreset coin", int'(coin), 0);
    chk("midreset reject", int'(reject), 0);
    chk("midreset jam", int'(jam), 0);
    chk("midreset busy", int'(busy), 0);
    coin_sense = 1'b0;
    idle(3);
    rst = 1'b0;
    act = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (coin != 4'b0000 || reject || jam || busy) act++;
    end
    chk("post-reset activity", act, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
